// File: rtl/ev_buffer_multi.sv
// Multi-entry write-back buffer between the data cache and the memory arbiter.
// Absorbs dirty lines in one cycle, serves read hits locally, drains FIFO-ordered to memory.
module ev_buffer_multi #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned LINE_W      = 256,
   parameter int unsigned OFFSET_W    = 5,
   parameter int unsigned EAGER_DRAIN = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ADDR_W-1:0]          mem_address,
   input  logic                       mem_read,
   input  logic                       mem_write,
   input  logic [LINE_W-1:0]          mem_wdata,
   output logic                       ev_resp,
   output logic [LINE_W-1:0]          ev_rdata,
   input  logic                       pmem_resp,
   input  logic [LINE_W-1:0]          pmem_rdata,
   output logic [ADDR_W-1:0]          pmem_address,
   output logic                       pmem_read,
   output logic                       pmem_write,
   output logic [LINE_W-1:0]          pmem_wdata,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] ev_count,
   output logic                       ev_full,
   output logic                       ev_empty,
   output logic [31:0]                ev_hits,
   output logic [31:0]                ev_writebacks
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam int unsigned TAG_W = ADDR_W - OFFSET_W;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                 state, state_nx;
   logic [DEPTH-1:0]       valid;
   logic [TAG_W-1:0]       tag_q  [DEPTH];
   logic [LINE_W-1:0]      data_q [DEPTH];
   logic [PTR_W-1:0]       head, tail;
   logic [TAG_W-1:0]       req_tag;
   logic                   hit;
   logic [PTR_W-1:0]       hit_idx;
   logic                   do_enq, do_upd, do_hit, do_pop;

   assign req_tag  = mem_address[ADDR_W-1:OFFSET_W];
   assign ev_full  = (ev_count == CNT_W'(DEPTH));
   assign ev_empty = (ev_count == '0);

   // Associative line match; coalescing guarantees at most one hit.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid[i] && (tag_q[i] == req_tag)) begin
            hit     = 1'b1;
            hit_idx = PTR_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         valid         <= '0;
         head          <= '0;
         tail          <= '0;
         ev_count      <= '0;
         ev_hits       <= '0;
         ev_writebacks <= '0;
      end else begin
         state <= state_nx;
         if (do_enq) begin
            valid[tail] <= 1'b1;
            tail        <= tail + 1'b1;
            ev_count    <= ev_count + 1'b1;
         end
         if (do_pop) begin
            valid[head]   <= 1'b0;
            head          <= head + 1'b1;
            ev_count      <= ev_count - 1'b1;
            ev_writebacks <= ev_writebacks + 32'd1;
         end
         if (do_hit) ev_hits <= ev_hits + 32'd1;
      end
   end

   // Line storage needs no reset; occupancy is tracked by valid.
   always_ff @(posedge clk) begin
      if (do_enq) begin
         tag_q[tail]  <= req_tag;
         data_q[tail] <= mem_wdata;
      end else if (do_upd) begin
         data_q[hit_idx] <= mem_wdata;
      end
   end

   always_comb begin
      state_nx     = state;
      ev_resp      = 1'b0;
      ev_rdata     = '0;
      pmem_address = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_wdata   = '0;
      do_enq       = 1'b0;
      do_upd       = 1'b0;
      do_hit       = 1'b0;
      do_pop       = 1'b0;
      case (state)
         IDLE: begin
            if (mem_write) begin
               if (hit) begin
                  ev_resp = 1'b1;
                  do_upd  = 1'b1;
               end else if (!ev_full) begin
                  ev_resp = 1'b1;
                  do_enq  = 1'b1;
               end else begin
                  state_nx = DRAIN;
               end
            end else if (mem_read) begin
               if (hit) begin
                  ev_resp  = 1'b1;
                  ev_rdata = data_q[hit_idx];
                  do_hit   = 1'b1;
               end else begin
                  state_nx = READ;
               end
            end else if (!ev_empty && ((EAGER_DRAIN != 0) || flush || ev_full)) begin
               state_nx = DRAIN;
            end
         end
         READ: begin
            pmem_read    = 1'b1;
            pmem_address = mem_address;
            ev_rdata     = pmem_rdata;
            ev_resp      = pmem_resp;
            if (pmem_resp) state_nx = IDLE;
         end
         DRAIN: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_q[head], {OFFSET_W{1'b0}}};
            pmem_wdata   = data_q[head];
            if (pmem_resp) begin
               do_pop   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
